// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - circular trace buffer of pipeline-latch snapshots with trigger/post-capture.
// Define TRACE_OVERFLOW_FLAG_EN to add the sticky overflow output.
module pipe_trace_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 8,
   parameter int POST   = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       capture_en,
   input  logic                       trig,
   input  logic                       clear,
   input  logic [DATA_W-1:0]          snap,
   input  logic                       rd_en,
   input  logic [$clog2(DEPTH)-1:0]   rd_idx,
   output logic [DATA_W-1:0]          rd_data,
   output logic [CNT_W-1:0]           rd_cycle,
   output logic                       rd_valid,
   output logic [$clog2(DEPTH):0]     count,
   output logic [CNT_W-1:0]           cycle_count,
   output logic [1:0]                 state
`ifdef TRACE_OVERFLOW_FLAG_EN
   ,
   output logic                       overflow
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] POST_LAST = AW'((POST == 0) ? 0 : POST - 1);
   localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_POST  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                   cur, nxt;
   logic [AW-1:0]            wr_ptr;
   logic [AW-1:0]            post_cnt, post_cnt_nxt;
   logic [AW-1:0]            rd_addr;
   logic                     wr_en;
   logic                     rd_hit;
   logic [CNT_W+DATA_W-1:0]  mem [DEPTH];

   assign state   = cur;
   assign rd_hit  = ({1'b0, rd_idx} < count);
   // count[AW-1:0] is zero when full, which makes the oldest entry sit at wr_ptr
   assign rd_addr = wr_ptr - count[AW-1:0] + rd_idx;

   always_ff @(posedge clock) begin
      if (reset) begin
         cur      <= S_IDLE;
         post_cnt <= '0;
      end else begin
         cur      <= nxt;
         post_cnt <= post_cnt_nxt;
      end
   end

   always_comb begin
      nxt          = cur;
      wr_en        = 1'b0;
      post_cnt_nxt = post_cnt;
      if (clear) begin
         nxt = S_IDLE;
      end else begin
         case (cur)
            S_IDLE: begin
               if (capture_en) nxt = S_ARMED;
            end
            S_ARMED: begin
               if (!capture_en) begin
                  nxt = S_IDLE;
               end else begin
                  wr_en = 1'b1;
                  if (trig) begin
                     post_cnt_nxt = '0;
                     nxt          = (POST == 0) ? S_DONE : S_POST;
                  end
               end
            end
            S_POST: begin
               if (capture_en) begin
                  wr_en        = 1'b1;
                  post_cnt_nxt = post_cnt + 1'b1;
                  if (post_cnt == POST_LAST) nxt = S_DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en && !reset) mem[wr_ptr] <= {cycle_count, snap};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_count <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         rd_cycle    <= '0;
`ifdef TRACE_OVERFLOW_FLAG_EN
         overflow    <= 1'b0;
`endif
      end else begin
         cycle_count <= cycle_count + 1'b1;
         if (clear) begin
            wr_ptr   <= '0;
            count    <= '0;
`ifdef TRACE_OVERFLOW_FLAG_EN
            overflow <= 1'b0;
`endif
         end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count != FULL) begin
               count <= count + 1'b1;
            end
`ifdef TRACE_OVERFLOW_FLAG_EN
            else begin
               overflow <= 1'b1;
            end
`endif
         end
         // Memory read sees pre-write contents when addresses collide
         rd_valid <= rd_en && rd_hit;
         if (rd_en && rd_hit) {rd_cycle, rd_data} <= mem[rd_addr];
      end
   end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb/tb_pipe_trace_buffer.sv - scoreboard bench for pipe_trace_buffer (DEPTH=16, POST=4).
module tb_pipe_trace_buffer;

   logic        clock = 1'b0;
   logic        reset, capture_en, trig, clear, rd_en;
   logic [31:0] snap;
   logic [3:0]  rd_idx;
   logic [31:0] rd_data;
   logic [7:0]  rd_cycle;
   logic        rd_valid;
   logic [4:0]  count;
   logic [7:0]  cycle_count;
   logic [1:0]  state;
`ifdef TRACE_OVERFLOW_FLAG_EN
   logic        overflow;
`endif

   pipe_trace_buffer #(.DATA_W(32), .DEPTH(16), .CNT_W(8), .POST(4)) dut (
      .clock(clock), .reset(reset), .capture_en(capture_en), .trig(trig),
      .clear(clear), .snap(snap), .rd_en(rd_en), .rd_idx(rd_idx),
      .rd_data(rd_data), .rd_cycle(rd_cycle), .rd_valid(rd_valid),
      .count(count), .cycle_count(cycle_count), .state(state)
`ifdef TRACE_OVERFLOW_FLAG_EN
      , .overflow(overflow)
`endif
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0]  cyc;
      logic [31:0] dat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   exp_t last_exp;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] exp_cc = 8'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      if (reset) exp_cc = 8'd0;
      else       exp_cc = exp_cc + 8'd1;
      #1;
   endtask

   task automatic rd_ok(input logic [3:0] idx, input logic [7:0] cyc, input logic [31:0] dat);
      rd_en  = 1'b1;
      rd_idx = idx;
      sb.push_back({cyc, dat});
      tick();
      rd_en = 1'b0;
      tick();
   endtask

   task automatic rd_bad(input logic [3:0] idx);
      rd_en  = 1'b1;
      rd_idx = idx;
      tick();
      rd_en = 1'b0;
      chk("rd_valid_oob", {63'd0, rd_valid}, 64'd0);
      chk("rd_hold", {24'd0, rd_cycle, rd_data}, {24'd0, last_exp});
      tick();
   endtask

   // Monitor: every presented read result is matched against the scoreboard head
   always @(negedge clock) begin
      if (rd_valid === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected actual=%0h:%0h required=none", rd_cycle, rd_data);
         end else begin
            mon_e    = sb.pop_front();
            last_exp = mon_e;
            if ({rd_cycle, rd_data} !== mon_e) begin
               errors++;
               $display("FAIL rd_entry actual=%0h:%0h required=%0h:%0h",
                        rd_cycle, rd_data, mon_e.cyc, mon_e.dat);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; capture_en = 1'b0; trig = 1'b0; clear = 1'b0;
      rd_en = 1'b0; rd_idx = 4'd0; snap = 32'd0; last_exp = '0;
      tick(); tick();
      chk("rst_cc", {56'd0, cycle_count}, 64'd0);
      chk("rst_count", {59'd0, count}, 64'd0);
      chk("rst_state", {62'd0, state}, 64'd0);
      chk("rst_rd", {23'd0, rd_valid, rd_cycle, rd_data}, 64'd0);
      reset = 1'b0;
      repeat (10) tick();
      chk("idle_cc", {56'd0, cycle_count}, 64'd10);
      chk("idle_count", {59'd0, count}, 64'd0);
      chk("idle_state", {62'd0, state}, 64'd0);

      // Trigger on 6th capture, 4 post entries; writes at cycles 11..20
      capture_en = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         snap = i;
         trig = (i == 5);
         tick();
         trig = 1'b0;
         if (i == 5) chk("post_state", {62'd0, state}, 64'd2);
      end
      chk("done_state", {62'd0, state}, 64'd3);
      chk("done_count", {59'd0, count}, 64'd10);
      snap = 32'd99; trig = 1'b1;
      tick();
      trig = 1'b0;
      chk("done_hold_state", {62'd0, state}, 64'd3);
      chk("done_hold_count", {59'd0, count}, 64'd10);
      capture_en = 1'b0;
      rd_ok(4'd9, 8'd20, 32'd9);
      rd_ok(4'd0, 8'd11, 32'd0);
      rd_bad(4'd10);

      // 20 captures without trigger; writes at cycles 30..49
      chk("c_cc", {56'd0, cycle_count}, 64'd28);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_state", {62'd0, state}, 64'd0);
      chk("clr_count", {59'd0, count}, 64'd0);
      capture_en = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) begin
         snap = 100 + i;
         tick();
      end
      capture_en = 1'b0;
      tick();
      chk("full_count", {59'd0, count}, 64'd16);
      chk("disarm_state", {62'd0, state}, 64'd0);
`ifdef TRACE_OVERFLOW_FLAG_EN
      chk("overflow_set", {63'd0, overflow}, 64'd1);
`endif
      rd_ok(4'd0, 8'd34, 32'd104);
      rd_ok(4'd15, 8'd49, 32'd119);

      // 200 captures starting at cycle 250
      clear = 1'b1;
      tick();
      clear = 1'b0;
`ifdef TRACE_OVERFLOW_FLAG_EN
      chk("overflow_clr", {63'd0, overflow}, 64'd0);
`endif
      for (int n = 0; n < 300 && exp_cc != 8'd249; n++) tick();
      chk("d_cc", {56'd0, cycle_count}, 64'd249);
      capture_en = 1'b1;
      tick();
      for (int i = 0; i < 200; i++) begin
         snap = 1000 + i;
         tick();
      end
      capture_en = 1'b0;
      tick();
      chk("d_count", {59'd0, count}, 64'd16);
      rd_ok(4'd0, 8'd178, 32'd1184);
      rd_ok(4'd15, 8'd193, 32'd1199);

      // Short capture straddling the counter wrap: cycles 250..255,0..3
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int n = 0; n < 300 && exp_cc != 8'd249; n++) tick();
      capture_en = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         snap = 2000 + i;
         tick();
      end
      capture_en = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) begin
         rd_ok(4'(i), 8'(250 + i), 32'(2000 + i));
      end

      // clear and trig together while in POST
      clear = 1'b1;
      tick();
      clear = 1'b0;
      capture_en = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         snap = 3000 + i;
         trig = (i == 2);
         tick();
      end
      chk("e_post", {62'd0, state}, 64'd2);
      clear = 1'b1; trig = 1'b1;
      tick();
      clear = 1'b0; trig = 1'b0; capture_en = 1'b0;
      chk("e_state", {62'd0, state}, 64'd0);
      chk("e_count", {59'd0, count}, 64'd0);
      rd_bad(4'd0);

      // reset in POST with seven entries
      capture_en = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) begin
         snap = 3500 + i;
         trig = (i == 4);
         tick();
      end
      trig = 1'b0;
      chk("f_state", {62'd0, state}, 64'd2);
      chk("f_count", {59'd0, count}, 64'd7);
      reset = 1'b1; capture_en = 1'b0;
      tick();
      reset = 1'b0;
      last_exp = '0;
      chk("f_rst_cc", {56'd0, cycle_count}, 64'd0);
      chk("f_rst_count", {59'd0, count}, 64'd0);
      chk("f_rst_state", {62'd0, state}, 64'd0);
      chk("f_rst_rd", {23'd0, rd_valid, rd_cycle, rd_data}, 64'd0);
`ifdef TRACE_OVERFLOW_FLAG_EN
      chk("f_rst_ovf", {63'd0, overflow}, 64'd0);
`endif
      capture_en = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         snap = 4000 + i;
         tick();
      end
      capture_en = 1'b0;
      tick();
      chk("f_recount", {59'd0, count}, 64'd3);
      rd_ok(4'd0, 8'd1, 32'd4000);
      rd_ok(4'd2, 8'd3, 32'd4002);
      rd_bad(4'd3);

      repeat (3) tick();
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
